// File: rtl/sat_engine_ctrl.sv
// Sat Engine bin-pass sequencer: drives state_list through the CDCL
// imply/decide/analyze/backtrack loop and reports the bin result.
module sat_engine_ctrl #(
  parameter int WIDTH_LVL    = 16,
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_CNT    = 16,
  parameter int WIDTH_WDOG   = 12,
  parameter int MAX_WAIT     = 4000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
  input  logic                    all_assigned_i,
  output logic                    start_decision_o,
  input  logic                    done_decision_i,
  output logic                    apply_imply_o,
  input  logic                    done_imply_i,
  input  logic                    find_conflict_i,
  output logic                    apply_analyze_o,
  input  logic                    done_analyze_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
  output logic                    apply_bkt_cur_bin_o,
  input  logic                    done_bkt_cur_bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [1:0]              result_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  output logic [WIDTH_CNT-1:0]    num_decisions_o,
  output logic [WIDTH_CNT-1:0]    num_conflicts_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_IMPLY, S_DECIDE, S_WAIT_DEC, S_ANALYZE,
    S_WAIT_ANA, S_BKT, S_WAIT_BKT, S_DONE
  } state_t;

  localparam logic [1:0] R_SAT     = 2'd0;
  localparam logic [1:0] R_BKT     = 2'd1;
  localparam logic [1:0] R_UNSAT   = 2'd2;
  localparam logic [1:0] R_TIMEOUT = 2'd3;

  localparam logic [WIDTH_WDOG-1:0] WDOG_MAX = WIDTH_WDOG'(MAX_WAIT - 1);
  localparam logic [WIDTH_CNT-1:0]  CNT_MAX  = {WIDTH_CNT{1'b1}};

  state_t                  state_q, state_d;
  logic [WIDTH_WDOG-1:0]   wdog_q, wdog_d;
  logic [WIDTH_CNT-1:0]    ndec_q, ndec_d;
  logic [WIDTH_CNT-1:0]    ncon_q, ncon_d;
  logic [1:0]              res_q, res_d;
  logic [WIDTH_BIN_ID-1:0] bbin_q, bbin_d;
  logic [WIDTH_LVL-1:0]    blvl_q, blvl_d;
  logic                    busy_q, done_q, imply_q;
  logic                    dec_q, ana_q, bkt_q;
  logic                    wdog_go, timeout;
  logic                    inc_dec, inc_con, clr;

  assign timeout = (wdog_q == WDOG_MAX);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    bbin_d  = bbin_q;
    blvl_d  = blvl_q;
    wdog_go = 1'b0;
    inc_dec = 1'b0;
    inc_con = 1'b0;
    clr     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_IMPLY;
          clr     = 1'b1;
          res_d   = '0;
          bbin_d  = '0;
          blvl_d  = '0;
        end
      end
      S_IMPLY: begin
        wdog_go = 1'b1;
        if (find_conflict_i) begin
          state_d = S_ANALYZE;
          inc_con = 1'b1;
        end else if (done_imply_i) begin
          if (all_assigned_i) begin
            state_d = S_DONE;
            res_d   = R_SAT;
          end else begin
            state_d = S_DECIDE;
            inc_dec = 1'b1;
          end
        end else if (timeout) begin
          state_d = S_DONE;
          res_d   = R_TIMEOUT;
        end
      end
      S_DECIDE:  state_d = S_WAIT_DEC;
      S_WAIT_DEC: begin
        wdog_go = 1'b1;
        if (done_decision_i) begin
          state_d = S_IMPLY;
        end else if (timeout) begin
          state_d = S_DONE;
          res_d   = R_TIMEOUT;
        end
      end
      S_ANALYZE: state_d = S_WAIT_ANA;
      S_WAIT_ANA: begin
        wdog_go = 1'b1;
        if (done_analyze_i) begin
          bbin_d = bkt_bin_i;
          blvl_d = bkt_lvl_i;
          if (bkt_lvl_i == '0) begin
            state_d = S_DONE;
            res_d   = R_UNSAT;
          end else if (bkt_bin_i != cur_bin_num_i) begin
            state_d = S_DONE;
            res_d   = R_BKT;
          end else begin
            state_d = S_BKT;
          end
        end else if (timeout) begin
          state_d = S_DONE;
          res_d   = R_TIMEOUT;
        end
      end
      S_BKT:     state_d = S_WAIT_BKT;
      S_WAIT_BKT: begin
        wdog_go = 1'b1;
        if (done_bkt_cur_bin_i) begin
          state_d = S_IMPLY;
        end else if (timeout) begin
          state_d = S_DONE;
          res_d   = R_TIMEOUT;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Abort freezes stats/result/bkt and only forces the state home.
    if (abort_i) begin
      state_d = S_IDLE;
      res_d   = res_q;
      bbin_d  = bbin_q;
      blvl_d  = blvl_q;
      inc_dec = 1'b0;
      inc_con = 1'b0;
      clr     = 1'b0;
    end

    if (clr)
      ndec_d = '0;
    else if (inc_dec && ndec_q != CNT_MAX)
      ndec_d = ndec_q + WIDTH_CNT'(1);
    else
      ndec_d = ndec_q;

    if (clr)
      ncon_d = '0;
    else if (inc_con && ncon_q != CNT_MAX)
      ncon_d = ncon_q + WIDTH_CNT'(1);
    else
      ncon_d = ncon_q;

    if (state_d != state_q || !wdog_go)
      wdog_d = '0;
    else
      wdog_d = wdog_q + WIDTH_WDOG'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wdog_q  <= '0;
      ndec_q  <= '0;
      ncon_q  <= '0;
      res_q   <= '0;
      bbin_q  <= '0;
      blvl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      imply_q <= 1'b0;
      dec_q   <= 1'b0;
      ana_q   <= 1'b0;
      bkt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      ndec_q  <= ndec_d;
      ncon_q  <= ncon_d;
      res_q   <= res_d;
      bbin_q  <= bbin_d;
      blvl_q  <= blvl_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      imply_q <= (state_d == S_IMPLY);
      dec_q   <= (state_d == S_DECIDE);
      ana_q   <= (state_d == S_ANALYZE);
      bkt_q   <= (state_d == S_BKT);
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign apply_imply_o       = imply_q;
  assign start_decision_o    = dec_q;
  assign apply_analyze_o     = ana_q;
  assign apply_bkt_cur_bin_o = bkt_q;
  assign result_o            = res_q;
  assign bkt_bin_o           = bbin_q;
  assign bkt_lvl_o           = blvl_q;
  assign num_decisions_o     = ndec_q;
  assign num_conflicts_o     = ncon_q;

endmodule

// File: tb/tb_sat_engine_ctrl.sv
// Directed bench for sat_engine_ctrl; expected bin results are queued
// at stimulus time and popped by a monitor on every done_o.
module tb_sat_engine_ctrl;

  typedef struct packed {
    logic [1:0]  res;
    logic [9:0]  bin;
    logic [15:0] lvl;
    logic [15:0] nd;
    logic [15:0] nc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [9:0]  cur_bin_num_i = 10'd5;
  logic        all_assigned_i = 1'b0;
  logic        start_decision_o;
  logic        done_decision_i = 1'b0;
  logic        apply_imply_o;
  logic        done_imply_i = 1'b0;
  logic        find_conflict_i = 1'b0;
  logic        apply_analyze_o;
  logic        done_analyze_i = 1'b0;
  logic [9:0]  bkt_bin_i = '0;
  logic [15:0] bkt_lvl_i = '0;
  logic        apply_bkt_cur_bin_o;
  logic        done_bkt_cur_bin_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  result_o;
  logic [9:0]  bkt_bin_o;
  logic [15:0] bkt_lvl_o;
  logic [15:0] num_decisions_o;
  logic [15:0] num_conflicts_o;

  always #5 clk = ~clk;

  sat_engine_ctrl #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .abort_i(abort_i),
    .cur_bin_num_i(cur_bin_num_i),
    .all_assigned_i(all_assigned_i),
    .start_decision_o(start_decision_o),
    .done_decision_i(done_decision_i),
    .apply_imply_o(apply_imply_o),
    .done_imply_i(done_imply_i),
    .find_conflict_i(find_conflict_i),
    .apply_analyze_o(apply_analyze_o),
    .done_analyze_i(done_analyze_i),
    .bkt_bin_i(bkt_bin_i), .bkt_lvl_i(bkt_lvl_i),
    .apply_bkt_cur_bin_o(apply_bkt_cur_bin_o),
    .done_bkt_cur_bin_i(done_bkt_cur_bin_i),
    .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o),
    .bkt_bin_o(bkt_bin_o), .bkt_lvl_o(bkt_lvl_o),
    .num_decisions_o(num_decisions_o),
    .num_conflicts_o(num_conflicts_o)
  );

  int   vecs = 0;
  int   errs = 0;
  int   n_dec = 0;
  int   n_ana = 0;
  int   n_bkt = 0;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [1:0] r, input logic [9:0] b,
                            input logic [15:0] l, input logic [15:0] nd,
                            input logic [15:0] nc);
    exp_t e;
    e = '{res: r, bin: b, lvl: l, nd: nd, nc: nc};
    exp_q.push_back(e);
  endtask

  task automatic wait_out(input int k, input string nm);
    logic [3:0] s;
    for (int i = 0; i < 30; i++) begin
      s = {apply_bkt_cur_bin_o, apply_analyze_o,
           start_decision_o, apply_imply_o};
      if (s[k]) return;
      step();
    end
    vecs++;
    errs++;
    $display("FAIL wait_%s: got timeout expected pulse", nm);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (!busy_o) return;
      step();
    end
    vecs++;
    errs++;
    $display("FAIL idle_%s: got busy expected idle", nm);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic imply_done(input logic assigned);
    all_assigned_i = assigned;
    done_imply_i   = 1'b1;
    step();
    done_imply_i   = 1'b0;
    all_assigned_i = 1'b0;
  endtask

  task automatic conflict();
    find_conflict_i = 1'b1;
    step();
    find_conflict_i = 1'b0;
  endtask

  task automatic analyze(input logic [9:0] b, input logic [15:0] l);
    wait_out(2, "analyze");
    step();
    bkt_bin_i      = b;
    bkt_lvl_i      = l;
    done_analyze_i = 1'b1;
    step();
    done_analyze_i = 1'b0;
  endtask

  task automatic monitor();
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_dec += int'(start_decision_o);
        n_ana += int'(apply_analyze_o);
        n_bkt += int'(apply_bkt_cur_bin_o);
        if (done_o) begin
          a = '{res: result_o, bin: bkt_bin_o, lvl: bkt_lvl_o,
                nd: num_decisions_o, nc: num_conflicts_o};
          if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL done_unexpected: got %0h expected none", a);
          end else begin
            e = exp_q.pop_front();
            chk("done_result", 64'(a), 64'(e));
          end
        end
      end
    end
  endtask

  int n;

  initial begin
    fork
      monitor();
    join_none

    step();
    step();
    chk("rst_ctl", {busy_o, done_o, start_decision_o, apply_imply_o,
                    apply_analyze_o, apply_bkt_cur_bin_o, result_o}, 0);
    chk("rst_data", {bkt_bin_o, bkt_lvl_o, num_decisions_o,
                     num_conflicts_o}, 0);
    rst = 1'b1;
    step();

    // 1: immediate SAT
    expect_res(2'd0, 10'd0, 16'd0, 16'd0, 16'd0);
    do_start();
    chk("t1_busy", busy_o, 1);
    wait_out(0, "t1_imply");
    imply_done(1'b1);
    wait_idle("t1");

    // 2: three decisions then SAT; stray start while busy
    n_dec = 0;
    expect_res(2'd0, 10'd0, 16'd0, 16'd3, 16'd0);
    do_start();
    for (int r = 0; r < 3; r++) begin
      wait_out(0, "t2_imply");
      imply_done(1'b0);
      wait_out(1, "t2_dec");
      step();
      if (r == 1) start_i = 1'b1;
      done_decision_i = 1'b1;
      step();
      done_decision_i = 1'b0;
      start_i = 1'b0;
    end
    wait_out(0, "t2_imply4");
    imply_done(1'b1);
    wait_idle("t2");
    chk("t2_dec_pulses", n_dec, 3);

    // 3: in-bin backtrack then SAT
    n_ana = 0;
    n_bkt = 0;
    expect_res(2'd0, 10'd5, 16'd3, 16'd0, 16'd1);
    do_start();
    wait_out(0, "t3_imply");
    conflict();
    analyze(10'd5, 16'd3);
    wait_out(3, "t3_bkt");
    step();
    done_bkt_cur_bin_i = 1'b1;
    step();
    done_bkt_cur_bin_i = 1'b0;
    chk("t3_reimply", apply_imply_o, 1);
    chk("t3_conflicts", num_conflicts_o, 1);
    imply_done(1'b1);
    wait_idle("t3");
    chk("t3_bkt_pulses", n_bkt, 1);
    chk("t3_ana_pulses", n_ana, 1);

    // 4a: backtrack to another bin
    n_bkt = 0;
    expect_res(2'd1, 10'd2, 16'd7, 16'd0, 16'd1);
    do_start();
    wait_out(0, "t4_imply");
    conflict();
    analyze(10'd2, 16'd7);
    wait_idle("t4a");
    chk("t4a_bkt_bin", bkt_bin_o, 2);
    chk("t4a_bkt_lvl", bkt_lvl_o, 7);
    chk("t4a_no_bkt", n_bkt, 0);

    // 4b: level 0 means UNSAT
    expect_res(2'd2, 10'd2, 16'd0, 16'd0, 16'd1);
    do_start();
    wait_out(0, "t4b_imply");
    conflict();
    analyze(10'd2, 16'd0);
    wait_idle("t4b");
    chk("t4b_result", result_o, 2);

    // 5: conflict beats done_imply
    n_dec = 0;
    expect_res(2'd1, 10'd2, 16'd4, 16'd0, 16'd1);
    do_start();
    wait_out(0, "t5_imply");
    find_conflict_i = 1'b1;
    done_imply_i    = 1'b1;
    step();
    find_conflict_i = 1'b0;
    done_imply_i    = 1'b0;
    chk("t5_analyze", apply_analyze_o, 1);
    analyze(10'd2, 16'd4);
    wait_idle("t5");
    chk("t5_no_dec", n_dec, 0);

    // 6: watchdog in WAIT_DEC
    expect_res(2'd3, 10'd0, 16'd0, 16'd1, 16'd0);
    do_start();
    wait_out(0, "t6_imply");
    imply_done(1'b0);
    wait_out(1, "t6_dec");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (done_o) break;
    end
    chk("t6_timeout_cycles", n, 9);
    wait_idle("t6");

    // 7: abort mid-IMPLY keeps stats
    do_start();
    wait_out(0, "t7_imply");
    imply_done(1'b0);
    wait_out(1, "t7_dec");
    step();
    done_decision_i = 1'b1;
    step();
    done_decision_i = 1'b0;
    wait_out(0, "t7_imply2");
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("t7_busy", busy_o, 0);
    chk("t7_imply_off", apply_imply_o, 0);
    chk("t7_ndec_kept", num_decisions_o, 1);
    chk("t7_result_kept", result_o, 0);
    repeat (4) step();

    // 8: reset mid-pass
    do_start();
    wait_out(0, "t8_imply");
    imply_done(1'b0);
    wait_out(1, "t8_dec");
    rst = 1'b0;
    step();
    chk("t8_rst_ctl", {busy_o, done_o, start_decision_o, apply_imply_o,
                       apply_analyze_o, apply_bkt_cur_bin_o, result_o}, 0);
    chk("t8_rst_data", {bkt_bin_o, bkt_lvl_o, num_decisions_o,
                        num_conflicts_o}, 0);
    rst = 1'b1;
    repeat (5) step();

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
